// File: rtl/booth_multiplier_8bit.sv
// rtl/booth_multiplier_8bit.sv - sequential radix-2 Booth multiplier, 8x8 signed -> 16-bit signed
//
// eight_bit_adder_subtractor: combinational 8-bit add (opcode=0) / subtract A-B (opcode=1)
//   A, B      : 8-bit operands
//   opcode    : 0 = A+B, 1 = A-B
//   sum       : 8-bit result
//   carry     : carry out of the 9-bit internal sum
//   overflow  : signed two's-complement overflow of the 8-bit result
//
// booth_multiplier_8bit: one multiply per start, eight iterations through one adder/subtractor
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : launch request, sampled only in IDLE
//   multiplicand : signed M, captured on the accepting edge
//   multiplier   : signed Q, captured on the accepting edge
//   product      : signed M*Q, updated only when the last iteration completes
//   busy         : high while iterating
//   done         : one-cycle completion pulse

module eight_bit_adder_subtractor (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       opcode,
  output logic [7:0] sum,
  output logic       carry,
  output logic       overflow
);

  logic [7:0] b_eff;
  logic [8:0] full;

  // Subtraction is A + ~B + 1; overflow is judged on the effective addend.
  always_comb begin
    b_eff    = opcode ? ~B : B;
    full     = {1'b0, A} + {1'b0, b_eff} + {8'b0, opcode};
    sum      = full[7:0];
    carry    = full[8];
    overflow = (A[7] == b_eff[7]) && (full[7] != A[7]);
  end

endmodule

module booth_multiplier_8bit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  multiplicand,
  input  logic [7:0]  multiplier,
  output logic [15:0] product,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  acc_q, acc_d;
  logic [7:0]  q_q, q_d;
  logic        qm1_q, qm1_d;
  logic [7:0]  m_q, m_d;
  logic [3:0]  count_q, count_d;
  logic [15:0] product_q, product_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [1:0]  booth_bits;
  logic        add_op;
  logic [7:0]  add_sum;
  logic        add_ovf;
  logic        unused_carry;
  logic [7:0]  r;
  logic        v;
  logic [7:0]  acc_shift;
  logic [7:0]  q_shift;

  assign booth_bits = {q_q[0], qm1_q};
  assign add_op     = (booth_bits == 2'b10);

  eight_bit_adder_subtractor u_addsub (
    .A        (acc_q),
    .B        (m_q),
    .opcode   (add_op),
    .sum      (add_sum),
    .carry    (unused_carry),
    .overflow (add_ovf)
  );

  // State register and datapath flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= 8'h00;
      q_q       <= 8'h00;
      qm1_q     <= 1'b0;
      m_q       <= 8'h00;
      count_q   <= 4'd0;
      product_q <= 16'h0000;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      qm1_q     <= qm1_d;
      m_q       <= m_d;
      count_q   <= count_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (count_q == 4'd7) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so busy/done carry no comb path.
  always_comb begin
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // Booth iteration datapath.
  always_comb begin
    acc_d     = acc_q;
    q_d       = q_q;
    qm1_d     = qm1_q;
    m_d       = m_q;
    count_d   = count_q;
    product_d = product_q;

    if (booth_bits == 2'b01 || booth_bits == 2'b10) begin
      r = add_sum;
      v = add_ovf;
    end else begin
      r = acc_q;
      v = 1'b0;
    end

    // On 8-bit overflow r[7] is the wrong sign of the true 9-bit value, so
    // flipping it recovers the correct shifted-in sign bit.
    acc_shift = {r[7] ^ v, r[7:1]};
    q_shift   = {r[0], q_q[7:1]};

    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = 8'h00;
          q_d     = multiplier;
          qm1_d   = 1'b0;
          m_d     = multiplicand;
          count_d = 4'd0;
        end
      end
      RUN: begin
        acc_d = acc_shift;
        q_d   = q_shift;
        qm1_d = q_q[0];
        if (count_q == 4'd7) begin
          product_d = {acc_shift, q_shift};
        end else begin
          count_d = count_q + 4'd1;
        end
      end
      default: begin
      end
    endcase
  end

  assign product = product_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_booth_multiplier_8bit.sv
// tb/tb_booth_multiplier_8bit.sv - directed self-checking bench for booth_multiplier_8bit

module tb_booth_multiplier_8bit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  multiplicand;
  logic [7:0]  multiplier;
  logic [15:0] product;
  logic        busy;
  logic        done;

  int n_cmp;
  int n_bad;
  logic [15:0] last_prod;

  booth_multiplier_8bit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product      (product),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    multiplicand = 8'h00;
    multiplier = 8'h00;
    #3;
    n_cmp++;
    if (product !== 16'h0000) begin n_bad++; $display("FAIL reset_product got %h want 0000", product); end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++;
    if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
    step();
    step();
    rst_n = 1'b1;
    last_prod = 16'h0000;
    step();
  endtask

  // Full launch-to-idle check of one multiply, timing and result.
  task automatic test_multiply(input logic [7:0] a, input logic [7:0] b,
                               input logic [15:0] exp, input string name);
    start = 1'b1;
    multiplicand = a;
    multiplier = b;
    step();  // E0
    start = 1'b0;
    multiplicand = ~a;
    multiplier = ~b;
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_e0 busy=%b done=%b want busy=1 done=0", name, busy, done);
    end
    for (int i = 1; i <= 7; i++) begin
      step();
      n_cmp++;
      if (busy !== 1'b1 || done !== 1'b0 || product !== last_prod) begin
        n_bad++;
        $display("FAIL %s_run_e%0d busy=%b done=%b product=%h want 1 0 %h", name, i, busy, done, product, last_prod);
      end
    end
    step();  // E8
    n_cmp++;
    if (product !== exp) begin n_bad++; $display("FAIL %s_product got %h want %h", name, product, exp); end
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_e8 done=%b busy=%b want done=1 busy=0", name, done, busy);
    end
    last_prod = exp;
    step();  // E9
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0 || product !== exp) begin
      n_bad++;
      $display("FAIL %s_e9 done=%b busy=%b product=%h want 0 0 %h", name, done, busy, product, exp);
    end
  endtask

  task automatic test_start_ignored();
    start = 1'b1;
    multiplicand = 8'h73;
    multiplier = 8'h1E;
    step();  // E0
    start = 1'b0;
    step();
    step();
    start = 1'b1;  // retrigger during RUN with other operands
    multiplicand = 8'h44;
    multiplier = 8'hA3;
    step();
    start = 1'b0;
    for (int i = 4; i <= 7; i++) step();
    step();  // E8
    n_cmp++;
    if (product !== 16'h0D7A || done !== 1'b1) begin
      n_bad++;
      $display("FAIL ignore_start product=%h done=%b want 0d7a 1", product, done);
    end
    last_prod = 16'h0D7A;
    step();
    step();
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL ignore_start_idle busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_reset_mid();
    start = 1'b1;
    multiplicand = 8'h7F;
    multiplier = 8'h81;
    step();  // E0
    start = 1'b0;
    for (int i = 1; i <= 4; i++) step();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (product !== 16'h0000 || busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid product=%h busy=%b done=%b want 0000 0 0", product, busy, done);
    end
    for (int i = 0; i < 6; i++) begin
      step();
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_mid_hold done=%b busy=%b want 0 0", done, busy);
      end
    end
    rst_n = 1'b1;
    last_prod = 16'h0000;
    step();
    test_multiply(8'hC7, 8'h4F, 16'hEE69, "after_reset");
  endtask

  task automatic test_back_to_back();
    int first_k;
    int second_k;
    int pulses;
    first_k = -1;
    second_k = -1;
    pulses = 0;
    start = 1'b1;
    multiplicand = 8'h80;
    multiplier = 8'h80;
    for (int k = 0; k < 22; k++) begin
      step();
      n_cmp++;
      if (busy === 1'b1 && done === 1'b1) begin
        n_bad++;
        $display("FAIL b2b_overlap cycle %0d busy=%b done=%b want not both", k, busy, done);
      end
      if (done === 1'b1) begin
        pulses++;
        if (first_k < 0) begin
          first_k = k;
          n_cmp++;
          if (product !== 16'h4000) begin n_bad++; $display("FAIL b2b_first got %h want 4000", product); end
          multiplicand = 8'h7F;
          multiplier = 8'h80;
        end else if (second_k < 0) begin
          second_k = k;
          n_cmp++;
          if (product !== 16'hC080) begin n_bad++; $display("FAIL b2b_second got %h want c080", product); end
        end
      end
    end
    start = 1'b0;
    n_cmp++;
    if (pulses !== 2) begin n_bad++; $display("FAIL b2b_pulses got %0d want 2", pulses); end
    n_cmp++;
    if (first_k !== 8 || second_k !== 18) begin
      n_bad++;
      $display("FAIL b2b_spacing first=%0d second=%0d want 8 18", first_k, second_k);
    end
    for (int i = 0; i < 12; i++) step();
    last_prod = 16'hC080;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_drain busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    last_prod = 16'h0000;
    test_reset();
    test_multiply(8'h73, 8'h1E, 16'h0D7A, "m115x30");
    test_multiply(8'h44, 8'hA3, 16'hE74C, "m68xn93");
    test_multiply(8'hC7, 8'h4F, 16'hEE69, "mn57x79");
    test_multiply(8'h81, 8'h7F, 16'hC0FF, "mn127x127");
    test_multiply(8'h80, 8'h80, 16'h4000, "mn128xn128");
    test_multiply(8'h7F, 8'h80, 16'hC080, "m127xn128");
    test_multiply(8'h00, 8'h80, 16'h0000, "m0xn128");
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
